control_sequencer: RTL
======================

# control_sequencer

Issues decoded instructions into the control datapath and drives `instruction_id`, `clock_counter` and `interrupt_stage`, the three inputs the registered select-signal block consumes. It sits between the instruction decoder and the control select logic. It holds multi-cycle instructions for their full length and inserts the three-stage interrupt entry sequence at instruction boundaries. It also inserts a one-cycle bubble after a taken branch.

## Interface
- `INT_ID`, default 8'hFF: reserved instruction id presented during interrupt entry. It is non-zero, so select logic is not forced to its idle state.
- `clk` input 1: rising-edge clock.
- `reset_n` input 1: reset, synchronous, active-low.
- `dec_id` input 8: instruction id from the decoder.
- `dec_valid` input 1: `dec_id` is a valid new instruction.
- `dec_ready` output 1: combinational. Sequencer accepts `dec_id` this cycle.
- `branch_taken` input 1: execute stage resolves the current branch as taken.
- `irq_req` input 1: level interrupt request.
- `i_flag` input 1: global interrupt enable (SREG I).
- `instruction_id` output 8: id currently executing.
- `clock_counter` output 2: remaining cycles of the current instruction, counting down to 0.
- `interrupt_stage` output 2: 0 = none; otherwise 2, 1, 3 in sequence.
- `irq_ack` output 1: one-cycle pulse in the first interrupt stage.
- `busy` output 1: `clock_counter != 0` or `interrupt_stage != 0`.

## Operation
- **Cycle length per id** (load value = length - 1):
  - RCALL 0x2C: 3 cycles.
  - RET 0x2D: 4 cycles.
  - RETI 0x2E: 4 cycles.
  - LPM 0x22: 3 cycles.
  - PUSH 0x2B: 2 cycles.
  - POP 0x2A: 2 cycles.
  - LD 0x19: 2 cycles.
  - ST 0x38: 2 cycles.
  - RJMP 0x2F: 2 cycles.
  - All others, including branches 0x04–0x08: 1 cycle.
- **Boundary:** `clock_counter == 0`, `interrupt_stage == 0`, and no bubble pending.
- **Readiness:** `dec_ready = boundary && !(irq_req && i_flag)`.
- **Accept** (`dec_valid && dec_ready`): `instruction_id <= dec_id` and `clock_counter <= length-1`.
- **Hold:** while `clock_counter > 0`, `instruction_id` holds and `clock_counter` decrements by 1 per cycle.
- **Idle:** at a boundary with no accept and no interrupt, `instruction_id <= 8'h00` and `clock_counter <= 0`.
- **Interrupt entry:** at a boundary with `irq_req && i_flag`:
  - `interrupt_stage` steps 2 → 1 → 3 → 0 on successive cycles.
  - `instruction_id = INT_ID` for all three stages. `clock_counter = 0`.
  - `irq_ack` is high only in stage 2.
  - Stage 2 pushes PC_low, stage 1 pushes PC_high, stage 3 loads the vector.
  - After stage 3 the block returns to boundary. The interrupt is not re-entered unless `irq_req && i_flag` is still high at that point.
- **Taken branch:** `branch_taken` is sampled only when `instruction_id` is 0x04–0x08 and `clock_counter == 0`. If high, the next cycle is a bubble:
  - `instruction_id = 8'h00`, `dec_ready = 0`.
  - The boundary follows in the cycle after the bubble.
- `branch_taken` is ignored for all other ids.
- Valid instructions offered while `dec_ready = 0` are not consumed. The decoder holds `dec_id`/`dec_valid`.

## Timing
- All outputs except `dec_ready` are registered and update on the rising edge.
- Accept at edge N: `instruction_id` and `clock_counter` valid from edge N until the next accept.
- An n-cycle instruction occupies exactly n cycles. Back-to-back 1-cycle instructions sustain 1 per cycle.
- Interrupt entry costs 3 cycles. Entry latency from `irq_req` rising is at most 4 cycles (the longest remaining instruction) plus 1.
- **Simultaneous events:**
  - At a boundary, interrupt has priority over `dec_valid`; the instruction waits.
  - `irq_req` arriving during a multi-cycle instruction or a bubble waits for the boundary.
  - `irq_req` falling mid-sequence does not abort the entry sequence.
- **Reset** (`reset_n = 0` at an edge), including mid-instruction or mid-interrupt, aborts with no completion. Next state:
  - `instruction_id = 0`, `clock_counter = 0`, `interrupt_stage = 0`.
  - `irq_ack = 0`, `busy = 0`, bubble cleared.
  - `dec_ready` follows its equation on the first cycle after reset.
- **Counter width:** 2 bits, maximum load 3. Decrement never wraps, because it is gated by `clock_counter > 0`.

## Test plan
- **Reset:** reset then release, `dec_valid = 0` → all outputs 0 and `dec_ready = 1`. Apply reset during RET at counter 2 → next cycle id 0x00, counter 0.
- **RCALL:** `dec_id = 0x2C` accepted → counter 2, 1, 0 on three cycles, id 0x2C throughout, `dec_ready` low for the first two cycles. Then ADD 0x01 accepted on the fourth cycle.
- **Interrupt:** `irq_req = 1`, `i_flag = 1` during the PUSH 0x2B first cycle → PUSH completes, then stage 2 (`irq_ack = 1`, id 0xFF), stage 1, stage 3, then 0. The pending `dec_valid` instruction is accepted the following cycle.
- **Masked interrupt:** `irq_req = 1`, `i_flag = 0` → no stage change. Stream of 1-cycle ids 0x0D, 0x41, 0x12 issues one per cycle.
- **Taken branch:** branch 0x05 with `branch_taken = 1` → next cycle id 0x00, `dec_ready = 0`, then accept resumes. Same with `branch_taken = 0` → no bubble.
- **Simultaneous:** boundary with `dec_valid` (0x38) and `irq_req` together → interrupt sequence first. ST issued after stage 3 and takes 2 cycles.

Source files
------------

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
//
// Bundles the decoder-side handshake, the branch/interrupt status inputs and
// the issued-instruction outputs of control_sequencer.
//
// Handshake: dec_valid/dec_ready follow strict valid/ready semantics. An
// instruction is transferred on a rising clk edge where dec_valid and
// dec_ready are both high. Once dec_valid is raised, the decoder holds dec_id
// and dec_valid steady until that transfer happens. dec_ready is
// combinational and may depend on irq_req, i_flag and branch_taken in the
// same cycle. dec_ready never depends on dec_valid.
//
// Signals
//   dec_id[7:0]          decoder -> sequencer   instruction id offered
//   dec_valid            decoder -> sequencer   dec_id holds a new instruction
//   dec_ready            sequencer -> decoder   instruction taken this cycle
//   branch_taken         execute -> sequencer   current branch resolved taken
//   irq_req              irq ctl -> sequencer   level interrupt request
//   i_flag               SREG    -> sequencer   global interrupt enable
//   instruction_id[7:0]  sequencer -> select    id currently executing
//   clock_counter[1:0]   sequencer -> select    remaining cycles, counts to 0
//   interrupt_stage[1:0] sequencer -> select    0 none, else 2 -> 1 -> 3
//   irq_ack              sequencer -> irq ctl   pulse in first interrupt stage
//   busy                 sequencer -> status    counter or interrupt active
//
// Modports: master = decoder/execute side, slave = sequencer.
// ---------------------------------------------------------------------------
interface control_sequencer_if;
    logic [7:0] dec_id;
    logic       dec_valid;
    logic       dec_ready;
    logic       branch_taken;
    logic       irq_req;
    logic       i_flag;
    logic [7:0] instruction_id;
    logic [1:0] clock_counter;
    logic [1:0] interrupt_stage;
    logic       irq_ack;
    logic       busy;

    modport master (
        output dec_id, dec_valid, branch_taken, irq_req, i_flag,
        input  dec_ready, instruction_id, clock_counter, interrupt_stage,
               irq_ack, busy
    );

    modport slave (
        input  dec_id, dec_valid, branch_taken, irq_req, i_flag,
        output dec_ready, instruction_id, clock_counter, interrupt_stage,
               irq_ack, busy
    );
endinterface

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Issues decoded instructions to the control select logic. Multi-cycle
// instructions are held for their full length with a down-counter. A
// three-stage interrupt entry sequence is inserted at instruction
// boundaries. One bubble cycle follows a taken branch.
//
// Parameters
//   INT_ID        id presented during all interrupt entry stages
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous, active-low reset
//   bus           control_sequencer_if.slave (see interface for signal list)
//   dbg_state     current FSM state encoding, for checkers and debug
//
// All bus outputs except dec_ready are registered.
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter logic [7:0] INT_ID = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    control_sequencer_if.slave    bus,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,  // executing or at a boundary
        ST_BUBBLE = 3'd1,  // dead cycle after a taken branch
        ST_INT2   = 3'd2,  // interrupt stage 2: push PC low, ack
        ST_INT1   = 3'd3,  // interrupt stage 1: push PC high
        ST_INT3   = 3'd4   // interrupt stage 3: load vector
    } state_t;

    state_t     state;
    logic [7:0] id_q;
    logic [1:0] cnt_q;
    logic [1:0] stage_q;
    logic       ack_q;
    logic       busy_q;

    logic       is_branch;
    logic       take_branch;
    logic       irq_pending;
    logic       boundary;
    logic       accept;

    // Load value is the instruction length minus one.
    function automatic logic [1:0] load_value(input logic [7:0] id);
        logic [1:0] v;
        case (id)
            8'h2D, 8'h2E:                      v = 2'd3;  // RET, RETI
            8'h2C, 8'h22:                      v = 2'd2;  // RCALL, LPM
            8'h2B, 8'h2A, 8'h19, 8'h38, 8'h2F: v = 2'd1;  // PUSH POP LD ST RJMP
            default:                           v = 2'd0;
        endcase
        return v;
    endfunction

    assign is_branch   = (id_q >= 8'h04) && (id_q <= 8'h08);
    // A branch resolves in its only cycle; a taken one marks the bubble as
    // pending immediately so the wrong-path instruction is not consumed.
    assign take_branch = (state == ST_RUN) && is_branch && (cnt_q == 2'd0)
                         && bus.branch_taken;
    assign irq_pending = bus.irq_req && bus.i_flag;
    assign boundary    = (state == ST_RUN) && (cnt_q == 2'd0) && !take_branch;
    assign accept      = boundary && !irq_pending && bus.dec_valid;

    assign bus.dec_ready       = boundary && !irq_pending;
    assign bus.instruction_id  = id_q;
    assign bus.clock_counter   = cnt_q;
    assign bus.interrupt_stage = stage_q;
    assign bus.irq_ack         = ack_q;
    assign bus.busy            = busy_q;
    assign dbg_state           = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_RUN;
            id_q    <= 8'h00;
            cnt_q   <= 2'd0;
            stage_q <= 2'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q  <= cnt_q - 2'd1;
                        busy_q <= (cnt_q != 2'd1);
                    end else if (take_branch) begin
                        state  <= ST_BUBBLE;
                        id_q   <= 8'h00;
                        busy_q <= 1'b0;
                    end else if (irq_pending) begin
                        state   <= ST_INT2;
                        id_q    <= INT_ID;
                        stage_q <= 2'd2;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (accept) begin
                        id_q   <= bus.dec_id;
                        cnt_q  <= load_value(bus.dec_id);
                        busy_q <= (load_value(bus.dec_id) != 2'd0);
                    end else begin
                        id_q   <= 8'h00;
                        busy_q <= 1'b0;
                    end
                end
                ST_BUBBLE: begin
                    state <= ST_RUN;
                    id_q  <= 8'h00;
                end
                ST_INT2: begin
                    state   <= ST_INT1;
                    stage_q <= 2'd1;
                end
                ST_INT1: begin
                    state   <= ST_INT3;
                    stage_q <= 2'd3;
                end
                ST_INT3: begin
                    // Return to a boundary; re-entry only if still requested.
                    state   <= ST_RUN;
                    stage_q <= 2'd0;
                    id_q    <= 8'h00;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= ST_RUN;
                    id_q    <= 8'h00;
                    cnt_q   <= 2'd0;
                    stage_q <= 2'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
